// File: rtl/tty_sequencer.sv
// Character-cell terminal sequencer: turns a byte stream into frame-store cell writes,
// line/screen clears and cursor/scroll register updates for a 128x32 text screen.
module tty_sequencer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [6:0] DEF_ATTR   = 7'h07
) (
  input  logic        clk_data,
  input  logic        irst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        attr_we,
  input  logic [6:0]  attr_in,
  output logic        enb,
  output logic [7:0]  web,
  output logic [11:0] addrb,
  output logic [63:0] dinb,
  output logic        busy
);

  // state   | meaning
  // IDLE    | waiting for a byte, ch_ready high
  // PUT     | write one character cell at the cursor
  // CLRLINE | blank the physical row at top (scroll-in line)
  // CLRALL  | blank all 1024 words of the frame store
  // SCROLL  | write scroll register (idx 0)
  // CURX    | write cursor x register (idx 2)
  // CURY    | write cursor y register (idx 3)
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PUT     = 3'd1;
  localparam logic [2:0] CLRLINE = 3'd2;
  localparam logic [2:0] CLRALL  = 3'd3;
  localparam logic [2:0] SCROLL  = 3'd4;
  localparam logic [2:0] CURX    = 3'd5;
  localparam logic [2:0] CURY    = 3'd6;

  logic [2:0]  state;
  logic [6:0]  col;
  logic [4:0]  lrow;
  logic [4:0]  top;
  logic [6:0]  attr;
  logic [6:0]  op_attr;
  logic [7:0]  ch_reg;
  logic [9:0]  sweep;
  logic        rdy_en;
  logic [4:0]  prow;
  logic [15:0] put_cell;
  logic [15:0] blank_cell;

  assign prow       = lrow + top;
  assign put_cell   = {1'b0, op_attr, ch_reg};
  assign blank_cell = {1'b0, op_attr, BLANK_CHAR};
  // rdy_en keeps ch_ready low until the first edge after reset release
  assign ch_ready   = rdy_en && (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_data or posedge irst) begin
    if (irst) begin
      state   <= IDLE;
      col     <= '0;
      lrow    <= '0;
      top     <= '0;
      attr    <= DEF_ATTR;
      op_attr <= DEF_ATTR;
      ch_reg  <= '0;
      sweep   <= '0;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (attr_we) attr <= attr_in;
      case (state)
        IDLE: begin
          if (ch_valid && ch_ready) begin
            ch_reg  <= ch_data;
            op_attr <= attr;
            sweep   <= '0;
            if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
              state <= PUT;
            end else begin
              case (ch_data)
                8'h0D: begin
                  col   <= '0;
                  state <= CURX;
                end
                8'h08: begin
                  if (col != 7'd0) col <= col - 7'd1;
                  state <= CURX;
                end
                8'h0A: begin
                  if (lrow != 5'd31) begin
                    lrow  <= lrow + 5'd1;
                    state <= CURX;
                  end else begin
                    state <= CLRLINE;
                  end
                end
                8'h0C:   state <= CLRALL;
                default: state <= IDLE;
              endcase
            end
          end
        end
        PUT: begin
          if (col == 7'd127) begin
            col <= '0;
            if (lrow != 5'd31) begin
              lrow  <= lrow + 5'd1;
              state <= CURX;
            end else begin
              state <= CLRLINE;
            end
          end else begin
            col   <= col + 7'd1;
            state <= CURX;
          end
        end
        CLRLINE: begin
          if (sweep == 10'd31) begin
            sweep <= '0;
            top   <= top + 5'd1;
            state <= SCROLL;
          end else begin
            sweep <= sweep + 10'd1;
          end
        end
        CLRALL: begin
          if (sweep == 10'd1023) begin
            sweep <= '0;
            col   <= '0;
            lrow  <= '0;
            top   <= '0;
            state <= SCROLL;
          end else begin
            sweep <= sweep + 10'd1;
          end
        end
        SCROLL:  state <= CURX;
        CURX:    state <= CURY;
        CURY:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    enb   = 1'b0;
    web   = '0;
    addrb = '0;
    dinb  = '0;
    case (state)
      PUT: begin
        enb   = 1'b1;
        web   = 8'b11 << {col[1:0], 1'b0};
        addrb = {2'b00, prow, col[6:2]};
        dinb  = {4{put_cell}};
      end
      CLRLINE: begin
        enb   = 1'b1;
        web   = 8'hFF;
        addrb = {2'b00, top, sweep[4:0]};
        dinb  = {4{blank_cell}};
      end
      CLRALL: begin
        enb   = 1'b1;
        web   = 8'hFF;
        addrb = {2'b00, sweep};
        dinb  = {4{blank_cell}};
      end
      SCROLL: begin
        enb   = 1'b1;
        web   = 8'hFF;
        addrb = 12'h800;
        dinb  = {57'b0, 2'b00, top};
      end
      CURX: begin
        enb   = 1'b1;
        web   = 8'hFF;
        addrb = 12'h802;
        dinb  = {57'b0, col};
      end
      CURY: begin
        enb   = 1'b1;
        web   = 8'hFF;
        addrb = 12'h803;
        dinb  = {57'b0, 2'b00, prow};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tty_sequencer.sv
// Scoreboard bench for tty_sequencer: a cursor model queues expected frame-store
// writes per byte; a monitor pops and compares every enb cycle.
module tb_tty_sequencer;

  logic        clk_data = 1'b0;
  logic        irst;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        attr_we;
  logic [6:0]  attr_in;
  logic        enb;
  logic [7:0]  web;
  logic [11:0] addrb;
  logic [63:0] dinb;
  logic        busy;

  tty_sequencer dut (
    .clk_data (clk_data),
    .irst     (irst),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .attr_we  (attr_we),
    .attr_in  (attr_in),
    .enb      (enb),
    .web      (web),
    .addrb    (addrb),
    .dinb     (dinb),
    .busy     (busy)
  );

  always #5 clk_data = ~clk_data;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [83:0] exp_q[$];

  logic [6:0] m_col;
  logic [4:0] m_lrow;
  logic [4:0] m_top;
  logic [6:0] m_attr;

  task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // An empty queue yields an all-zero expectation, which no real write can match.
  always @(negedge clk_data) begin
    if (enb) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("extra_write", {addrb, web, dinb}, 84'd0);
      else chk("write", {addrb, web, dinb}, exp_q.pop_front());
    end else begin
      chk("idle_web", 84'(web), 84'd0);
    end
  end

  function automatic logic [4:0] m_prow();
    return m_lrow + m_top;
  endfunction

  task automatic push(input logic [11:0] a, input logic [7:0] w, input logic [63:0] d);
    exp_q.push_back({a, w, d});
  endtask

  task automatic model_curxy();
    push(12'h802, 8'hFF, {57'b0, m_col});
    push(12'h803, 8'hFF, {59'b0, m_prow()});
  endtask

  task automatic model_nl();
    if (m_lrow != 5'd31) begin
      m_lrow = m_lrow + 5'd1;
    end else begin
      for (int i = 0; i < 32; i++)
        push({2'b00, m_top, 5'(i)}, 8'hFF, {4{1'b0, m_attr, 8'h20}});
      m_top = m_top + 5'd1;
      push(12'h800, 8'hFF, {59'b0, m_top});
    end
  endtask

  task automatic model_byte(input logic [7:0] c);
    logic [7:0] w;
    if (c >= 8'h20 && c <= 8'h7E) begin
      case (m_col[1:0])
        2'd0: w = 8'h03;
        2'd1: w = 8'h0C;
        2'd2: w = 8'h30;
        default: w = 8'hC0;
      endcase
      push({2'b00, m_prow(), m_col[6:2]}, w, {4{1'b0, m_attr, c}});
      if (m_col == 7'd127) begin
        m_col = 7'd0;
        model_nl();
      end else begin
        m_col = m_col + 7'd1;
      end
      model_curxy();
    end else if (c == 8'h0D) begin
      m_col = 7'd0;
      model_curxy();
    end else if (c == 8'h08) begin
      if (m_col != 7'd0) m_col = m_col - 7'd1;
      model_curxy();
    end else if (c == 8'h0A) begin
      model_nl();
      model_curxy();
    end else if (c == 8'h0C) begin
      for (int i = 0; i < 1024; i++)
        push(12'(i), 8'hFF, {4{1'b0, m_attr, 8'h20}});
      m_col  = 7'd0;
      m_lrow = 5'd0;
      m_top  = 5'd0;
      push(12'h800, 8'hFF, 64'd0);
      model_curxy();
    end
  endtask

  task automatic model_reset();
    m_col  = 7'd0;
    m_lrow = 5'd0;
    m_top  = 5'd0;
    m_attr = 7'h07;
  endtask

  // Returns #1 after the accepting edge with ch_valid already dropped.
  task automatic drive_accept(input logic [7:0] c);
    int n;
    model_byte(c);
    @(negedge clk_data);
    ch_valid = 1'b1;
    ch_data  = c;
    n = 0;
    while (!ch_ready && n < 100) begin
      @(negedge clk_data);
      n++;
    end
    chk("accept", 84'(ch_ready), 84'd1);
    @(posedge clk_data);
    #1;
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    do begin
      @(negedge clk_data);
      lat++;
    end while (!ch_ready && lat < 3000);
    chk("back_idle", 84'(ch_ready), 84'd1);
    chk("drain", 84'(exp_q.size()), 84'd0);
  endtask

  task automatic send(input logic [7:0] c, output int lat);
    drive_accept(c);
    wait_idle(lat);
  endtask

  task automatic set_attr(input logic [6:0] a);
    @(negedge clk_data);
    attr_we = 1'b1;
    attr_in = a;
    @(negedge clk_data);
    attr_we = 1'b0;
    m_attr  = a;
  endtask

  initial begin
    int lat;
    int c0;
    irst     = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    attr_we  = 1'b0;
    attr_in  = 7'h00;
    model_reset();

    repeat (3) @(negedge clk_data);
    chk("rst_enb",   84'(enb),      84'd0);
    chk("rst_web",   84'(web),      84'd0);
    chk("rst_addrb", 84'(addrb),    84'd0);
    chk("rst_dinb",  84'(dinb),     84'd0);
    chk("rst_ready", 84'(ch_ready), 84'd0);
    chk("rst_busy",  84'(busy),     84'd0);
    irst = 1'b0;
    #1 chk("ready_before_edge", 84'(ch_ready), 84'd0);
    @(negedge clk_data);
    chk("ready_after_edge", 84'(ch_ready), 84'd1);

    send(8'h41, lat);
    chk("A_latency", 84'(lat), 84'd4);
    send(8'h0D, lat);
    c0 = wr_cnt;
    send(8'h08, lat);
    chk("bs_col0_writes", 84'(wr_cnt - c0), 84'd2);
    c0 = wr_cnt;
    send(8'h01, lat);
    chk("unknown_writes", 84'(wr_cnt - c0), 84'd0);
    chk("unknown_latency", 84'(lat), 84'd1);

    set_attr(7'h1E);
    send(8'h62, lat);
    send(8'h08, lat);
    set_attr(7'h07);

    // attr change mid-clear must not affect the blank words
    c0 = wr_cnt;
    fork
      send(8'h0C, lat);
      begin
        repeat (20) @(negedge clk_data);
        attr_we = 1'b1;
        attr_in = 7'h5A;
        @(negedge clk_data);
        attr_we = 1'b0;
        m_attr  = 7'h5A;
      end
    join
    chk("ff_writes", 84'(wr_cnt - c0), 84'd1027);
    chk("ff_latency", 84'(lat), 84'd1028);

    for (int i = 0; i < 5; i++) send(8'h0A, lat);
    for (int i = 0; i < 127; i++) send(8'(8'h21 + (i % 94)), lat);
    send(8'h5A, lat);
    chk("Z_latency", 84'(lat), 84'd4);
    for (int i = 0; i < 25; i++) send(8'h0A, lat);
    c0 = wr_cnt;
    send(8'h0A, lat);
    chk("lf31_writes", 84'(wr_cnt - c0), 84'd35);
    chk("lf31_latency", 84'(lat), 84'd36);
    send(8'h71, lat);

    set_attr(7'h07);
    drive_accept(8'h0C);
    repeat (500) @(posedge clk_data);
    #1;
    chk("ff500_enb",   84'(enb),   84'd1);
    chk("ff500_addrb", 84'(addrb), 84'd500);
    irst = 1'b1;
    #1;
    chk("abort_enb",  84'(enb),  84'd0);
    chk("abort_web",  84'(web),  84'd0);
    chk("abort_busy", 84'(busy), 84'd0);
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk_data);
    irst = 1'b0;
    send(8'h41, lat);
    chk("post_abort_latency", 84'(lat), 84'd4);

    repeat (3) @(negedge clk_data);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
